// File: rtl/pattern_tx.sv
// Serial pattern transmitter: repeats a PAT_W-bit pattern MSB-first with idle gaps.
// Optional parity cycle per repetition enabled by PATTERN_TX_PARITY_EN.
module pattern_tx #(
  parameter int PAT_W = 5,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] rep_num,
  input  logic [GAP_W-1:0] gap_len,
  output logic             data_out,
  output logic             bit_vld,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(PAT_W + 1);
`ifdef PATTERN_TX_PARITY_EN
  localparam int LAST = PAT_W;
`else
  localparam int LAST = PAT_W - 1;
`endif
  localparam logic [BW-1:0] LAST_BIT = BW'(LAST);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] sh_q, sh_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic             data_out_q, data_out_d;
  logic             bit_vld_q, bit_vld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] rep_dec;

  assign rep_dec = rep_q - CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    sh_d       = sh_q;
    bit_d      = bit_q;
    rep_d      = rep_q;
    gap_d      = gap_q;
    gcnt_d     = gcnt_q;
    data_out_d = 1'b0;
    bit_vld_d  = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SHIFT;
          pat_d      = pattern;
          sh_d       = pattern;
          rep_d      = (rep_num == '0) ? CNT_W'(1) : rep_num;
          gap_d      = gap_len;
          bit_d      = '0;
          data_out_d = pattern[PAT_W-1];
          bit_vld_d  = 1'b1;
          busy_d     = 1'b1;
        end
      end
      SHIFT: begin
        busy_d = 1'b1;
        if (bit_q == LAST_BIT) begin
          rep_d = rep_dec;
          if (rep_dec == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (gap_q != '0) begin
            state_d = GAP;
            gcnt_d  = GAP_W'(1);
          end else begin
            sh_d       = pat_q;
            bit_d      = '0;
            data_out_d = pat_q[PAT_W-1];
            bit_vld_d  = 1'b1;
          end
`ifdef PATTERN_TX_PARITY_EN
        end else if (bit_q == BW'(PAT_W - 1)) begin
          bit_d      = bit_q + BW'(1);
          data_out_d = ^pat_q;
          bit_vld_d  = 1'b1;
`endif
        end else begin
          sh_d       = sh_q << 1;
          bit_d      = bit_q + BW'(1);
          data_out_d = sh_d[PAT_W-1];
          bit_vld_d  = 1'b1;
        end
      end
      GAP: begin
        busy_d = 1'b1;
        if (gcnt_q == gap_q) begin
          state_d    = SHIFT;
          sh_d       = pat_q;
          bit_d      = '0;
          data_out_d = pat_q[PAT_W-1];
          bit_vld_d  = 1'b1;
        end else begin
          gcnt_d = gcnt_q + GAP_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pat_q      <= '0;
      sh_q       <= '0;
      bit_q      <= '0;
      rep_q      <= '0;
      gap_q      <= '0;
      gcnt_q     <= '0;
      data_out_q <= 1'b0;
      bit_vld_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      sh_q       <= sh_d;
      bit_q      <= bit_d;
      rep_q      <= rep_d;
      gap_q      <= gap_d;
      gcnt_q     <= gcnt_d;
      data_out_q <= data_out_d;
      bit_vld_q  <= bit_vld_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign data_out = data_out_q;
  assign bit_vld  = bit_vld_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_pattern_tx.sv
// Bench for pattern_tx: per-cycle comparison against a stream-level model.
// Random runs also toggle start and inputs mid-run to prove they are ignored.
module tb_pattern_tx;

  localparam int PAT_W = 5;
  localparam int CNT_W = 4;
  localparam int GAP_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic [CNT_W-1:0] rep_num = '0;
  logic [GAP_W-1:0] gap_len = '0;
  logic             data_out;
  logic             bit_vld;
  logic             busy;
  logic             done;

  int errs = 0;
  int checks = 0;

  logic [3:0] exp_q[$];

  pattern_tx #(
    .PAT_W(PAT_W),
    .CNT_W(CNT_W),
    .GAP_W(GAP_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pattern (pattern),
    .rep_num (rep_num),
    .gap_len (gap_len),
    .data_out(data_out),
    .bit_vld (bit_vld),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {data_out, bit_vld, busy, done};
  endfunction

  // Expected {data_out,bit_vld,busy,done} per cycle from the first bit cycle.
  function automatic void model(input logic [PAT_W-1:0] pat,
                                input int rep, input int gap);
    int n;
    logic par;
    n = (rep == 0) ? 1 : rep;
    par = ($countones(pat) % 2) == 1;
    exp_q.delete();
    for (int r = 0; r < n; r++) begin
      for (int b = PAT_W - 1; b >= 0; b--)
        exp_q.push_back({pat[b], 3'b110});
`ifdef PATTERN_TX_PARITY_EN
      exp_q.push_back({par, 3'b110});
`else
      if (par === 1'bx) exp_q.push_back(4'b0000);
`endif
      if (r < n - 1)
        for (int g = 0; g < gap; g++)
          exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0011);
  endfunction

  task automatic run(input string name, input logic [PAT_W-1:0] pat,
                     input int rep, input int gap, input bit noisy);
    model(pat, rep, gap);
    pattern = pat;
    rep_num = CNT_W'(rep);
    gap_len = GAP_W'(gap);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (noisy) begin
      pattern = PAT_W'($urandom);
      rep_num = CNT_W'($urandom);
      gap_len = GAP_W'($urandom);
    end
    foreach (exp_q[i]) begin
      chk($sformatf("%s_c%0d", name, i), 32'(outs()), 32'(exp_q[i]));
      if (noisy) start = 1'($urandom);
      @(posedge clk);
      #1;
    end
    chk($sformatf("%s_idle", name), 32'(outs()), 32'h0);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 32'(outs()), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle", 32'(outs()), 32'h0);

    run("p10010_r1", 5'b10010, 1, 0, 1'b0);
    run("p10010_r3g2", 5'b10010, 3, 2, 1'b0);
    run("p11011_r0", 5'b11011, 0, 0, 1'b0);
    run("p10010_r2", 5'b10010, 2, 0, 1'b0);
    run("p11010_r2", 5'b11010, 2, 0, 1'b0);
    run("busy_ign", 5'b10010, 2, 1, 1'b1);

    // Abort a run with reset three cycles in, then restart cleanly.
    pattern = 5'b10010;
    rep_num = CNT_W'(3);
    gap_len = GAP_W'(2);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("rst_run", 32'(outs()), 32'hE);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid", 32'(outs()), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_after", 32'(outs()), 32'h0);
    run("post_rst", 5'b01101, 2, 3, 1'b0);

    for (int k = 0; k < 30; k++)
      run($sformatf("rnd%0d", k), PAT_W'($urandom),
          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
